dram_fifo_mc: RTL and testbench

Multi-channel command generator and ring-buffer manager that turns the shared DDR3 SDRAM into N_CH independent FIFOs, one region per channel. Sits between per-channel FWFT input/output BRAM FIFOs and the MIG 7-series application interface, in the `uiclk` domain. It adds what the single-channel DRAM FIFO lacks: configurable channel count, region size and burst limits, a round-robin arbiter, full app_en/app_rdy and wdf handshakes, and tagged in-order read return.

---
 rtl/dram_fifo_mc.sv | 245 ++++++++++++++++++++++++
 tb/tb_dram_fifo_mc.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_fifo_mc.sv
// dram_fifo_mc: turns one MIG 7-series app port into N_CH ring-buffer FIFOs with round-robin bursts.
// Optional macro DRAM_FIFO_MC_STATUS_EN enables live status[7:1] and the sticky tag error flags.
module dram_fifo_mc #(
  parameter int N_CH      = 2,
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 24,
  parameter int REGION_W  = 23,
  parameter int BURST_MAX = 128,
  parameter int BURST_MIN = 32,
  parameter int PEND_MAX  = 31
) (
  input  logic                           uiclk,
  input  logic                           reset_n,
  input  logic                           init_calib_complete,
  input  logic [N_CH-1:0]                infifo_empty,
  input  logic [N_CH-1:0]                infifo_almost_empty,
  input  logic [N_CH*DATA_W-1:0]         infifo_do,
  output logic [N_CH-1:0]                infifo_rden,
  input  logic [N_CH-1:0]                outfifo_almost_full,
  output logic [N_CH-1:0]                outfifo_wren,
  output logic [DATA_W-1:0]              outfifo_di,
  output logic [ADDR_W-1:0]              app_addr,
  output logic [2:0]                     app_cmd,
  output logic                           app_en,
  input  logic                           app_rdy,
  output logic [DATA_W-1:0]              app_wdf_data,
  output logic                           app_wdf_wren,
  output logic                           app_wdf_end,
  input  logic                           app_wdf_rdy,
  input  logic [DATA_W-1:0]              app_rd_data,
  input  logic                           app_rd_data_valid,
  output logic [N_CH*(REGION_W+1)-1:0]   mem_fill,
  output logic [7:0]                     status
);
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int FW     = REGION_W + 1;
  localparam int CNT_W  = $clog2(BURST_MAX + 1);
  localparam int TAG_AW = $clog2(PEND_MAX + 1);
  localparam int PW     = TAG_AW + 1;
  localparam logic [FW-1:0]    REGION_WORDS = {1'b1, {REGION_W{1'b0}}};
  localparam logic [FW-1:0]    BMIN_L       = FW'(BURST_MIN);
  localparam logic [CNT_W-1:0] BMAX_L       = CNT_W'(BURST_MAX);
  localparam logic [PW-1:0]    PMAX_L       = PW'(PEND_MAX);
  localparam logic [PW-1:0]    TAG_DEPTH    = {1'b1, {TAG_AW{1'b0}}};
  localparam logic [CH_W-1:0]  LAST_CH      = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t state, state_nx;

  logic [REGION_W-1:0] wr_ptr [N_CH];
  logic [REGION_W-1:0] rd_ptr [N_CH];
  logic [FW-1:0]       fill   [N_CH];
  logic [CH_W-1:0]     cur, rr, pick;
  logic [CNT_W-1:0]    cnt;
  logic                pick_vld, pick_rd;
  logic [N_CH-1:0]     rd_ok, wr_ok;

  logic [CH_W-1:0]     tag_mem [2**TAG_AW];
  logic [TAG_AW-1:0]   tag_wp, tag_rp;
  logic [PW-1:0]       pending;

  logic                cmd_free, wdf_free, wr_go, rd_go, tag_push, tag_pop;
  logic [FW-1:0]       cur_fill, cur_free;

  assign cmd_free    = !app_en || app_rdy;
  assign wdf_free    = !app_wdf_wren || app_wdf_rdy;
  assign cur_fill    = fill[cur];
  assign cur_free    = REGION_WORDS - cur_fill;
  assign app_wdf_end = app_wdf_wren;

  always_comb begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      rd_ok[c] = (fill[c] != '0) && !outfifo_almost_full[c] && (pending < PMAX_L);
      wr_ok[c] = !infifo_almost_empty[c] && ((REGION_WORDS - fill[c]) >= BMIN_L);
    end
  end

  // Scan starts one past the last-served channel; a read on a channel beats a write on it.
  always_comb begin
    logic [CH_W-1:0] c;
    c        = rr;
    pick     = rr;
    pick_vld = 1'b0;
    pick_rd  = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      c = (c == LAST_CH) ? '0 : c + 1'b1;
      if (!pick_vld && (rd_ok[c] || wr_ok[c])) begin
        pick     = c;
        pick_vld = 1'b1;
        pick_rd  = rd_ok[c];
      end
    end
  end

  assign wr_go = init_calib_complete && (state == WRITE) && cmd_free && wdf_free &&
                 !infifo_empty[cur] && (cur_free != '0) && (cnt != BMAX_L);
  assign rd_go = init_calib_complete && (state == READ) && cmd_free && (cur_fill != '0) &&
                 !outfifo_almost_full[cur] && (pending < PMAX_L) && (cnt != BMAX_L);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_vld) state_nx = pick_rd ? READ : WRITE;
      WRITE:   if ((cnt == BMAX_L) || infifo_empty[cur] || (cur_free == '0)) state_nx = IDLE;
      READ:    if ((cnt == BMAX_L) || (cur_fill == '0) || outfifo_almost_full[cur] ||
                   (pending >= PMAX_L)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    infifo_rden = '0;
    if (wr_go) infifo_rden[cur] = 1'b1;
  end

  always_ff @(posedge uiclk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cur   <= '0;
      rr    <= LAST_CH;
      cnt   <= '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        fill[c]   <= '0;
      end
    end else if (!init_calib_complete) begin
      state <= IDLE;
      cur   <= '0;
      rr    <= LAST_CH;
      cnt   <= '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        fill[c]   <= '0;
      end
    end else begin
      state <= state_nx;
      if ((state == IDLE) && pick_vld) begin
        cur <= pick;
        rr  <= pick;
        cnt <= '0;
      end else if (wr_go || rd_go) begin
        cnt <= cnt + 1'b1;
      end
      if (wr_go) begin
        wr_ptr[cur] <= wr_ptr[cur] + 1'b1;
        fill[cur]   <= fill[cur] + 1'b1;
      end else if (rd_go) begin
        rd_ptr[cur] <= rd_ptr[cur] + 1'b1;
        fill[cur]   <= fill[cur] - 1'b1;
      end
    end
  end

  // Command and write-data registers hold their contents until the MIG accepts them.
  always_ff @(posedge uiclk or negedge reset_n) begin
    if (!reset_n) begin
      app_en       <= 1'b0;
      app_addr     <= '0;
      app_cmd      <= '0;
      app_wdf_wren <= 1'b0;
      app_wdf_data <= '0;
    end else if (!init_calib_complete) begin
      app_en       <= 1'b0;
      app_addr     <= '0;
      app_cmd      <= '0;
      app_wdf_wren <= 1'b0;
      app_wdf_data <= '0;
    end else begin
      if (wr_go || rd_go) begin
        app_en   <= 1'b1;
        app_addr <= ADDR_W'({cur, (wr_go ? wr_ptr[cur] : rd_ptr[cur])});
        app_cmd  <= wr_go ? 3'b000 : 3'b001;
      end else if (app_en && app_rdy) begin
        app_en <= 1'b0;
      end
      if (wr_go) begin
        app_wdf_wren <= 1'b1;
        app_wdf_data <= infifo_do[cur*DATA_W +: DATA_W];
      end else if (app_wdf_wren && app_wdf_rdy) begin
        app_wdf_wren <= 1'b0;
      end
    end
  end

  assign tag_push = rd_go && (pending != TAG_DEPTH);
  assign tag_pop  = app_rd_data_valid && (pending != '0);

  always_ff @(posedge uiclk) begin
    if (tag_push) tag_mem[tag_wp] <= cur;
  end

  always_ff @(posedge uiclk or negedge reset_n) begin
    if (!reset_n) begin
      tag_wp       <= '0;
      tag_rp       <= '0;
      pending      <= '0;
      outfifo_wren <= '0;
      outfifo_di   <= '0;
    end else if (!init_calib_complete) begin
      tag_wp       <= '0;
      tag_rp       <= '0;
      pending      <= '0;
      outfifo_wren <= '0;
      outfifo_di   <= '0;
    end else begin
      if (tag_push) tag_wp <= tag_wp + 1'b1;
      if (tag_pop)  tag_rp <= tag_rp + 1'b1;
      pending      <= pending + PW'(tag_push) - PW'(tag_pop);
      outfifo_wren <= '0;
      if (tag_pop) begin
        outfifo_wren[tag_mem[tag_rp]] <= 1'b1;
        outfifo_di                    <= app_rd_data;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_fill
    assign mem_fill[g*FW +: FW] = fill[g];
  end

`ifdef DRAM_FIFO_MC_STATUS_EN
  logic err_under, err_over;

  always_ff @(posedge uiclk or negedge reset_n) begin
    if (!reset_n) begin
      err_under <= 1'b0;
      err_over  <= 1'b0;
    end else if (!init_calib_complete) begin
      err_under <= 1'b0;
      err_over  <= 1'b0;
    end else begin
      if (app_rd_data_valid && (pending == '0)) err_under <= 1'b1;
      if (rd_go && (pending == TAG_DEPTH))      err_over  <= 1'b1;
    end
  end

  assign status = {3'(cur), err_over, err_under, (state == READ), (state == WRITE),
                   init_calib_complete};
`else
  assign status = {7'b0, init_calib_complete};
`endif

endmodule

// File: tb/tb_dram_fifo_mc.sv
// Randomized bench for dram_fifo_mc: per-channel end-to-end FIFO model plus a STRICT-ordering MIG model.
module tb_dram_fifo_mc;
  localparam int N_CH = 2, DW = 32, AW = 24, RW = 5, BMAX = 8, BMIN = 4, PMAX = 31;
  localparam int FW = RW + 1;

  logic               uiclk = 1'b0;
  logic               reset_n, calib;
  logic [N_CH-1:0]    infifo_empty, infifo_almost_empty, infifo_rden;
  logic [N_CH*DW-1:0] infifo_do;
  logic [N_CH-1:0]    outfifo_almost_full, outfifo_wren;
  logic [DW-1:0]      outfifo_di;
  logic [AW-1:0]      app_addr;
  logic [2:0]         app_cmd;
  logic               app_en, app_rdy;
  logic [DW-1:0]      app_wdf_data;
  logic               app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [DW-1:0]      app_rd_data;
  logic               app_rd_data_valid;
  logic [N_CH*FW-1:0] mem_fill;
  logic [7:0]         status;

  always #5 uiclk = ~uiclk;

  dram_fifo_mc #(.N_CH(N_CH), .DATA_W(DW), .ADDR_W(AW), .REGION_W(RW),
                 .BURST_MAX(BMAX), .BURST_MIN(BMIN), .PEND_MAX(PMAX)) dut (
    .uiclk(uiclk), .reset_n(reset_n), .init_calib_complete(calib),
    .infifo_empty(infifo_empty), .infifo_almost_empty(infifo_almost_empty),
    .infifo_do(infifo_do), .infifo_rden(infifo_rden),
    .outfifo_almost_full(outfifo_almost_full), .outfifo_wren(outfifo_wren),
    .outfifo_di(outfifo_di), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_rdy(app_rdy), .app_wdf_data(app_wdf_data), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy), .app_rd_data(app_rd_data),
    .app_rd_data_valid(app_rd_data_valid), .mem_fill(mem_fill), .status(status)
  );

  typedef struct { logic [AW-1:0] addr; int need; int ready; } rd_t;

  int            checks = 0, failures = 0;
  logic [DW-1:0] infq [N_CH][$];
  logic [DW-1:0] expq [N_CH][$];
  logic [AW-1:0] wcq[$];
  logic [DW-1:0] wdq[$];
  rd_t           rdq[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            wexp [N_CH];
  int            rexp [N_CH];
  int            wr_cmds = 0, wr_done = 0, cyc = 0, pop_ch = -1, quiet = 0;
  int            last_rd_ch = -1, rd_switches = 0;
  bit            rand_rdy = 0, hold_ret = 0, spurious = 0;
  logic [N_CH-1:0] oaf = '1;
  bit            prev_cmd_pend = 0, prev_wdf_pend = 0;
  logic [AW-1:0] prev_addr;
  logic [2:0]    prev_cmd;
  logic [DW-1:0] prev_wdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_words(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] w;
      w = $urandom;
      infq[c].push_back(w);
      expq[c].push_back(w);
    end
  endtask

  task automatic accept_cmd();
    int ch, off;
    ch  = int'(app_addr >> RW);
    off = int'(app_addr[RW-1:0]);
    check("cmd_region", ch < N_CH, 1);
    if (ch < N_CH) begin
      if (app_cmd == 3'b000) begin
        check("wr_addr", off, wexp[ch]);
        wexp[ch] = (wexp[ch] + 1) % (1 << RW);
        wcq.push_back(app_addr);
        wr_cmds++;
      end else begin
        check("rd_cmd", app_cmd, 3'b001);
        check("rd_addr", off, rexp[ch]);
        rexp[ch] = (rexp[ch] + 1) % (1 << RW);
        rdq.push_back('{addr: app_addr, need: wr_cmds, ready: cyc + 2 + int'($urandom_range(0, 4))});
        if (last_rd_ch >= 0 && ch != last_rd_ch) rd_switches++;
        last_rd_ch = ch;
      end
    end
  endtask

  // One clock: drive inputs on the falling edge, sample 1 time unit later.
  task automatic tick();
    @(negedge uiclk);
    cyc++;
    if (pop_ch >= 0) begin
      infq[pop_ch].delete(0);
      pop_ch = -1;
    end
    for (int c = 0; c < N_CH; c++) begin
      infifo_empty[c]        = (infq[c].size() == 0);
      infifo_almost_empty[c] = infifo_empty[c];
      infifo_do[c*DW +: DW]  = infifo_empty[c] ? '0 : infq[c][0];
    end
    outfifo_almost_full = oaf;
    app_rdy     = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    app_wdf_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    app_rd_data_valid = 1'b0;
    app_rd_data       = '0;
    if (spurious) begin
      app_rd_data_valid = 1'b1;
      app_rd_data       = $urandom;
      spurious          = 0;
    end else if (!hold_ret && rdq.size() > 0 && rdq[0].ready <= cyc && wr_done >= rdq[0].need &&
                 (!rand_rdy || $urandom_range(0, 1) == 1)) begin
      app_rd_data_valid = 1'b1;
      app_rd_data       = mem.exists(rdq[0].addr) ? mem[rdq[0].addr] : 'x;
      rdq.delete(0);
    end
    #1;
    if (prev_cmd_pend) begin
      check("cmd_hold_en", app_en, 1);
      check("cmd_hold_addr", app_addr, prev_addr);
      check("cmd_hold_cmd", app_cmd, prev_cmd);
    end
    if (prev_wdf_pend) check("wdf_hold", {app_wdf_wren, app_wdf_data}, {1'b1, prev_wdata});
    prev_cmd_pend = app_en && !app_rdy;
    prev_addr     = app_addr;
    prev_cmd      = app_cmd;
    prev_wdf_pend = app_wdf_wren && !app_wdf_rdy;
    prev_wdata    = app_wdf_data;
    if (app_en && app_rdy) accept_cmd();
    if (app_wdf_wren && app_wdf_rdy) wdq.push_back(app_wdf_data);
    while (wcq.size() > 0 && wdq.size() > 0) begin
      mem[wcq[0]] = wdq[0];
      wcq.delete(0);
      wdq.delete(0);
      wr_done++;
    end
    if (infifo_rden != '0) begin
      check("rden_onehot", $onehot(infifo_rden), 1);
      for (int c = 0; c < N_CH; c++)
        if (infifo_rden[c]) begin
          check("rden_nonempty", infq[c].size() > 0, 1);
          pop_ch = c;
        end
    end
    if (outfifo_wren != '0) begin
      check("wren_onehot", $onehot(outfifo_wren), 1);
      for (int c = 0; c < N_CH; c++)
        if (outfifo_wren[c]) begin
          if (expq[c].size() == 0) check("wren_unexpected", outfifo_wren, 0);
          else check("rd_data", outfifo_di, expq[c].pop_front());
        end
    end
    if (app_en || app_wdf_wren || infifo_rden != '0 || outfifo_wren != '0 || rdq.size() > 0 ||
        app_rd_data_valid) quiet = 0;
    else quiet++;
  endtask

  task automatic wait_quiet(input int budget, input string tag);
    int t;
    t = 0;
    quiet = 0;
    while (quiet < 20 && t < budget) begin
      tick();
      t++;
    end
    check({tag, "_timeout"}, quiet >= 20, 1);
  endtask

  task automatic clear_model();
    rdq.delete();
    wcq.delete();
    wdq.delete();
    for (int c = 0; c < N_CH; c++) begin
      infq[c].delete();
      expq[c].delete();
      wexp[c] = 0;
      rexp[c] = 0;
    end
    wr_cmds = 0;
    wr_done = 0;
    pop_ch = -1;
    prev_cmd_pend = 0;
    prev_wdf_pend = 0;
  endtask

  initial begin
    reset_n = 1'b1;
    calib = 1'b0;
    infifo_empty = '1;
    infifo_almost_empty = '1;
    infifo_do = '0;
    outfifo_almost_full = '1;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    app_rd_data = '0;
    app_rd_data_valid = 1'b0;
    clear_model();
    #1 reset_n = 1'b0;
    #2;
    check("rst_app_en", app_en, 0);
    check("rst_wdf_wren", app_wdf_wren, 0);
    check("rst_rden", infifo_rden, 0);
    check("rst_wren", outfifo_wren, 0);
    check("rst_mem_fill", mem_fill, 0);
    check("rst_status", status, 8'h00);
    calib = 1'b1;
    #1 check("rst_status_calib", status, 8'h01);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();

    // Ch0 writes while its outfifo is blocked, then drains in order.
    push_words(0, 20);
    oaf = '1;
    wait_quiet(500, "w20");
    check("fill0_w20", mem_fill[0 +: FW], 20);
    check("fill1_w20", mem_fill[FW +: FW], 0);
    check("infq0_drained", infq[0].size(), 0);
    oaf = '0;
    wait_quiet(2000, "r20");
    check("exp0_empty_r20", expq[0].size(), 0);
    check("fill0_r20", mem_fill[0 +: FW], 0);

    // Fill the region to capacity, then release so the write pointer wraps.
    oaf = '1;
    push_words(0, 40);
    wait_quiet(1000, "wfull");
    check("fill0_full", mem_fill[0 +: FW], 1 << RW);
    check("infq0_left", infq[0].size(), 8);
    oaf = '0;
    wait_quiet(3000, "wrap");
    check("exp0_empty_wrap", expq[0].size(), 0);
    check("infq0_empty_wrap", infq[0].size(), 0);

    // Both channels loaded, random handshakes, then released together.
    rand_rdy = 1;
    oaf = '1;
    push_words(0, 30);
    push_words(1, 30);
    wait_quiet(3000, "w2ch");
    check("fill0_2ch", mem_fill[0 +: FW], 30);
    check("fill1_2ch", mem_fill[FW +: FW], 30);
    rd_switches = 0;
    last_rd_ch = -1;
    oaf = '0;
    wait_quiet(5000, "r2ch");
    check("exp0_empty_2ch", expq[0].size(), 0);
    check("exp1_empty_2ch", expq[1].size(), 0);
    check("rd_burst_switches", rd_switches >= 3, 1);

    // Mixed random traffic with toggling outfifo backpressure.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) push_words(int'($urandom_range(0, N_CH - 1)), 1);
      if ($urandom_range(0, 15) == 0) oaf = 2'($urandom_range(0, 3));
      tick();
    end
    oaf = '0;
    wait_quiet(5000, "mixed");
    check("exp0_empty_mixed", expq[0].size(), 0);
    check("exp1_empty_mixed", expq[1].size(), 0);
    check("fill_zero_mixed", mem_fill, 0);

    // Reset while reads are outstanding.
    rand_rdy = 0;
    oaf = '1;
    push_words(0, 30);
    wait_quiet(1000, "wpre_rst");
    hold_ret = 1;
    oaf = '0;
    for (int i = 0; i < 300 && rdq.size() < 20; i++) tick();
    check("pending_reached", rdq.size() >= 20, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_app_en", app_en, 0);
    check("mid_rst_wdf_wren", app_wdf_wren, 0);
    check("mid_rst_rden", infifo_rden, 0);
    check("mid_rst_wren", outfifo_wren, 0);
    check("mid_rst_fill", mem_fill, 0);
    check("mid_rst_status", status[7:1], 0);
    clear_model();
    hold_ret = 0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("post_rst_fill", mem_fill, 0);
    check("post_rst_underflow", status[3], 0);

    // Read data with no command outstanding.
    spurious = 1;
    repeat (3) tick();
    check("spurious_no_wren", outfifo_wren, 0);
`ifdef DRAM_FIFO_MC_STATUS_EN
    check("spurious_underflow", status[3], 1);
`else
    check("spurious_underflow", status[3], 0);
`endif
    check("spurious_overflow", status[4], 0);

    // Normal traffic after reset.
    rand_rdy = 1;
    push_words(1, 15);
    push_words(0, 15);
    wait_quiet(3000, "post");
    check("exp0_empty_post", expq[0].size(), 0);
    check("exp1_empty_post", expq[1].size(), 0);
    check("fill_zero_post", mem_fill, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
